// File: rtl/fir_pkg.sv
// Shared defaults, sample type and controller state encoding for the FIR delay line.
package fir_pkg;

  localparam int unsigned FIR_DATA_W = 16;
  localparam int unsigned FIR_DEPTH  = 32;

  typedef logic [FIR_DATA_W-1:0] sample_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } dly_state_e;

endpackage : fir_pkg

// File: rtl/fir_dly_mem.sv
// Circular sample storage with a write pointer and newest-relative tap read.
// Optional macro FIR_DLY_REG_OUT_EN registers the tap read port (1-cycle latency).
module fir_dly_mem
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = FIR_DATA_W,
  parameter int unsigned DEPTH  = FIR_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     we_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_W-1:0]        rd_data_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wp_q;
  logic [AW-1:0]     rd_idx_c;

  // Storage and write pointer; clear and reset wipe every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wp_q <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wp_q <= '0;
    end else if (we_i) begin
      mem_q[wp_q] <= wdata_i;
      wp_q        <= wp_q + AW'(1);
    end
  end

  // Tap 0 is the entry just behind the write pointer; wrap is free at power-of-two depth.
  assign rd_idx_c = wp_q - AW'(1) - rd_addr_i;

`ifdef FIR_DLY_REG_OUT_EN
  logic [DATA_W-1:0] rd_q;

  // Registered tap read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (clear_i) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem_q[rd_idx_c];
    end
  end

  assign rd_data_o = rd_q;
`else
  assign rd_data_o = mem_q[rd_idx_c];
`endif

endmodule : fir_dly_mem

// File: rtl/fir_delay_line.sv
// FIR sample delay line: circular storage, zero-fill flush controller, saturating fill count.
// Optional macro FIR_DLY_REG_OUT_EN registers rd_data (see fir_dly_mem).
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W    = FIR_DATA_W,
  parameter int unsigned DEPTH     = FIR_DEPTH,
  parameter int unsigned FLUSH_LEN = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        sample_in,
  input  logic                     push,
  input  logic                     clear,
  input  logic                     flush_start,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   fill_cnt,
  output logic                     full,
  output logic                     busy,
  output logic                     flush_done
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  dly_state_e        state_q;
  logic [CW-1:0]     rem_q;
  logic [CW-1:0]     fill_q;
  logic              full_q;
  logic              busy_q;
  logic              done_q;
  logic              wr_en_c;
  logic [DATA_W-1:0] wr_data_c;

  // A flush overrides the sample with zero; clear discards any coincident push.
  assign wr_en_c   = push && !clear;
  assign wr_data_c = (state_q == FLUSH) ? '0 : sample_in;

  // Flush controller, remaining-zero counter and saturating fill counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      fill_q  <= '0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      rem_q   <= '0;
      fill_q  <= '0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push && !full_q) begin
        fill_q <= fill_q + CW'(1);
        full_q <= (fill_q == CW'(DEPTH - 1));
      end
      case (state_q)
        IDLE: begin
          if (flush_start) begin
            state_q <= FLUSH;
            busy_q  <= 1'b1;
            rem_q   <= CW'(FLUSH_LEN);
          end
        end
        FLUSH: begin
          if (push) begin
            rem_q <= rem_q - CW'(1);
            if (rem_q == CW'(1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fir_dly_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear),
    .we_i      (wr_en_c),
    .wdata_i   (wr_data_c),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign fill_cnt   = fill_q;
  assign full       = full_q;
  assign busy       = busy_q;
  assign flush_done = done_q;

endmodule : fir_delay_line
